// File: rtl/watch_pkg.sv
// Shared types and helpers for the settable watch: FSM states, segment
// constants and the digit/hour conversion functions used by the display.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    // Standard decimal patterns; anything above 9 cannot occur and is blanked.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Maps a BCD hour 00-23 to what the display shows. In 12-hour mode
    // midnight becomes 12 and the afternoon hours fold down to 01-11.
    function automatic logic [7:0] display_hour(input logic [7:0] hour_bcd,
                                                input logic       h12);
        logic [4:0] bin;
        logic [4:0] folded;
        logic [4:0] low;
        logic [7:0] result;
        bin    = {1'b0, hour_bcd[7:4]} * 5'd10 + {1'b0, hour_bcd[3:0]};
        folded = (bin == 5'd0)  ? 5'd12 :
                 (bin > 5'd12)  ? bin - 5'd12 : bin;
        low    = folded - 5'd10;
        if (!h12)
            result = hour_bcd;
        else if (folded >= 5'd10)
            result = {4'd1, low[3:0]};
        else
            result = {4'd0, folded[3:0]};
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MODULUS-1 back to 00. carry_out is
// high in the cycle an increment rolls the counter over, so chained fields
// all resolve on the same clock edge.
module bcd_mod_counter #(
    parameter int MODULUS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    output logic       carry_out,
    output logic [7:0] value
);

    localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);

    logic [3:0] tens;
    logic [3:0] ones;

    assign carry_out = inc && (tens == MAX_TENS) && (ones == MAX_ONES);
    assign value     = {tens, ones};

    // Clear wins over increment; the ones digit rolls into tens at 9.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (carry_out) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/settable_watch.sv
// 24-hour watch with set mode, blinking field during set, optional 12-hour
// presentation and a registered multiplexed 7-segment driver.
module settable_watch
    import watch_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_DIV = 10_000,
    parameter int DIGITS   = 6
) (
    input  logic              clk_i,
    input  logic              a_reset_i,
    input  logic              mode_i,
    input  logic              inc_i,
    input  logic              h12_i,
    output logic [6:0]        led_o,
    output logic [DIGITS-1:0] dig_o,
    output logic              sec_tick_o
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_MAX    = 3'(DIGITS - 1);
    // A 4-digit display skips the seconds, so its index 0 is minute ones.
    localparam logic [2:0]    POS_OFS    = (DIGITS == 4) ? 3'd2 : 3'd0;

    state_t        state;
    logic [PW-1:0] presc;
    logic          mode_prev;
    logic          inc_prev;
    logic [SW-1:0] scan;
    logic [2:0]    dig_idx;

    logic          mode_edge;
    logic          inc_edge;
    logic          tick;
    logic          sec_carry;
    logic          min_carry;
    logic          unused_day_carry;
    logic [7:0]    sec_val;
    logic [7:0]    min_val;
    logic [7:0]    hour_val;

    logic [7:0]    disp_hour;
    logic [2:0]    pos;
    logic [3:0]    digit;
    logic          blank;

    // A mode press in the same cycle as an increment press swallows the
    // increment, and in RUN it also swallows that cycle's second tick.
    assign mode_edge = mode_i & ~mode_prev;
    assign inc_edge  = inc_i & ~inc_prev & ~mode_edge;
    assign tick      = (presc == PRESC_MAX) && (state == RUN) && !mode_edge;

    bcd_mod_counter #(.MODULUS(60)) u_sec (
        .clk       (clk_i),
        .rst       (a_reset_i),
        .clear     (state == RUN && mode_edge),
        .inc       (tick),
        .carry_out (sec_carry),
        .value     (sec_val)
    );

    bcd_mod_counter #(.MODULUS(60)) u_min (
        .clk       (clk_i),
        .rst       (a_reset_i),
        .clear     (1'b0),
        .inc       ((tick && sec_carry) || (state == SET_M && inc_edge)),
        .carry_out (min_carry),
        .value     (min_val)
    );

    bcd_mod_counter #(.MODULUS(24)) u_hour (
        .clk       (clk_i),
        .rst       (a_reset_i),
        .clear     (1'b0),
        .inc       ((tick && sec_carry && min_carry) || (state == SET_H && inc_edge)),
        .carry_out (unused_day_carry),
        .value     (hour_val)
    );

    // Mode FSM, prescaler, button history and the registered second tick.
    // Button history loads the live level during reset so a button held
    // through reset release is not mistaken for a fresh press.
    always_ff @(posedge clk_i) begin
        if (a_reset_i) begin
            state      <= RUN;
            presc      <= '0;
            sec_tick_o <= 1'b0;
            mode_prev  <= mode_i;
            inc_prev   <= inc_i;
        end else begin
            mode_prev  <= mode_i;
            inc_prev   <= inc_i;
            sec_tick_o <= tick;
            if (presc == PRESC_MAX)
                presc <= '0;
            else
                presc <= presc + 1'b1;
            if (mode_edge) begin
                case (state)
                    RUN: begin
                        state <= SET_H;
                        presc <= '0;
                    end
                    SET_H: state <= SET_M;
                    SET_M: begin
                        state <= RUN;
                        presc <= '0;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    // Chooses the digit under the current scan index and decides whether
    // the field being edited is in the dark half of its blink period.
    always_comb begin
        disp_hour = display_hour(hour_val, h12_i);
        pos       = dig_idx + POS_OFS;
        digit     = 4'd0;
        case (pos)
            3'd0:    digit = sec_val[3:0];
            3'd1:    digit = sec_val[7:4];
            3'd2:    digit = min_val[3:0];
            3'd3:    digit = min_val[7:4];
            3'd4:    digit = disp_hour[3:0];
            3'd5:    digit = disp_hour[7:4];
            default: digit = 4'd0;
        endcase
        blank = (presc >= PRESC_HALF) &&
                ((state == SET_H && pos >= 3'd4) ||
                 (state == SET_M && (pos == 3'd2 || pos == 3'd3)));
    end

    // Scan timing and the output registers; dig_o and led_o are loaded from
    // the same index on the same edge so they can never disagree.
    always_ff @(posedge clk_i) begin
        if (a_reset_i) begin
            scan    <= '0;
            dig_idx <= 3'd0;
            dig_o   <= DIGITS'(1);
            led_o   <= SEG_ZERO;
        end else begin
            dig_o <= DIGITS'(1) << dig_idx;
            led_o <= blank ? SEG_BLANK : bcd_to_seg(digit);
            if (scan == SCAN_MAX) begin
                scan    <= '0;
                dig_idx <= (dig_idx == IDX_MAX) ? 3'd0 : dig_idx + 3'd1;
            end else begin
                scan <= scan + 1'b1;
            end
        end
    end

endmodule
